// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Pipeline stage register with valid/ready handshake, a
//                one-entry skid buffer, NOP bubbles and a saturating
//                stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                   PC_W      = 32,
    parameter int                   INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
    parameter int                   CNT_W     = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [PC_W-1:0]     pc_i,
    input  logic [INSTR_W-1:0]  instr_i,
    output logic                ready_o,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [PC_W-1:0]     pc_o,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                valid_q,      valid_d;
    logic [PC_W-1:0]     pc_q,         pc_d;
    logic [INSTR_W-1:0]  instr_q,      instr_d;
    logic                skid_v_q,     skid_v_d;
    logic [PC_W-1:0]     skid_pc_q,    skid_pc_d;
    logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]    stall_cnt_q,  stall_cnt_d;

    logic accept;
    logic adv;

    // Readiness depends only on skid occupancy, so no input-to-ready path.
    assign ready_o = ~skid_v_q;
    assign accept  = valid_i & ~skid_v_q;
    assign adv     = ready_i & ~stall_i;

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        skid_v_d     = skid_v_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush_i) begin
            valid_d  = 1'b0;
            instr_d  = NOP_INSTR;
            pc_d     = pc_i;
            skid_v_d = 1'b0;
        end else if (!valid_q) begin
            if (accept) begin
                valid_d = 1'b1;
                pc_d    = pc_i;
                instr_d = instr_i;
            end
        end else if (adv) begin
            if (skid_v_q) begin
                pc_d     = skid_pc_q;
                instr_d  = skid_instr_q;
                skid_v_d = 1'b0;
            end else if (accept) begin
                pc_d    = pc_i;
                instr_d = instr_i;
            end else begin
                // Drained: bubble keeps the last PC for debug visibility.
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        end else if (accept) begin
            skid_v_d     = 1'b1;
            skid_pc_d    = pc_i;
            skid_instr_d = instr_i;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !adv && !flush_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            instr_q      <= NOP_INSTR;
            skid_v_q     <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            skid_v_q     <= skid_v_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed plus randomized bench for pipe_stage_reg against a
//                two-deep FIFO reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          PC_W    = 32;
    localparam int          INSTR_W = 32;
    localparam int          CNT_W   = 3;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          CNT_SAT = 7;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               valid_i = 1'b0;
    logic [PC_W-1:0]    pc_i = '0;
    logic [INSTR_W-1:0] instr_i = '0;
    logic               stall_i = 1'b0;
    logic               flush_i = 1'b0;
    logic               ready_i = 1'b1;
    logic               ready_o;
    logic               valid_o;
    logic [PC_W-1:0]    pc_o;
    logic [INSTR_W-1:0] instr_o;
    logic [CNT_W-1:0]   stall_cnt_o;

    pipe_stage_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .ready_o     (ready_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .pc_o        (pc_o),
        .instr_o     (instr_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference: beats in flight as an ordered queue of {pc, instr}, at most 2.
    logic [63:0] m_q[$];
    logic [31:0] m_bpc;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [63:0] head;
        head = (m_q.size() > 0) ? m_q[0] : {m_bpc, NOP};
        chk({tag, ".valid"}, 64'(valid_o),     64'(m_q.size() > 0));
        chk({tag, ".pc"},    64'(pc_o),        64'(head[63:32]));
        chk({tag, ".instr"}, 64'(instr_o),     64'(head[31:0]));
        chk({tag, ".ready"}, 64'(ready_o),     64'(m_q.size() < 2));
        chk({tag, ".cnt"},   64'(stall_cnt_o), 64'(m_cnt));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_bpc = '0;
        m_cnt = 0;
    endtask

    // Called just after a rising edge; drives inputs, advances one cycle, checks.
    task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic st, input logic fl,
                         input logic rd);
        logic adv;
        logic acc;
        valid_i = v; pc_i = pc; instr_i = ins;
        stall_i = st; flush_i = fl; ready_i = rd;
        @(posedge clk);
        if (fl) begin
            m_q.delete();
            m_bpc = pc;
        end else begin
            adv = rd & ~st;
            acc = v && (m_q.size() < 2);
            if (m_q.size() > 0 && !adv && m_cnt < CNT_SAT) m_cnt++;
            if (adv && m_q.size() > 0) begin
                m_bpc = m_q[0][63:32];
                void'(m_q.pop_front());
            end
            if (acc) m_q.push_back({pc, ins});
        end
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        valid_i = 1'b1; pc_i = $urandom; instr_i = $urandom; stall_i = 1'b0; ready_i = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk_all("reset");
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset values, including the non-zero NOP pattern.
        do_reset();

        // Streaming A0..A3 with no back-pressure.
        for (int i = 0; i < 4; i++)
            cycle("streamA", 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
        cycle("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("drain_nop", 64'(instr_o), 64'(NOP));
        chk("drain_pc_hold", 64'(pc_o), 64'hC);

        // Stall for three cycles with B1 landing in the skid.
        do_reset();
        cycle("B0", 1'b1, 32'h100, 32'hB000_0000, 1'b0, 1'b0, 1'b1);
        cycle("B1_skid", 1'b1, 32'h104, 32'hB000_0001, 1'b1, 1'b0, 1'b1);
        chk("skid_ready_low", 64'(ready_o), 64'h0);
        cycle("stall2", 1'b1, 32'h108, 32'hB000_0002, 1'b1, 1'b0, 1'b1);
        cycle("stall3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("stall_cnt3", 64'(stall_cnt_o), 64'h3);
        cycle("rel_B1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rel_B1_pc", 64'(pc_o), 64'h104);
        cycle("rel_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Flush beats stall with the skid full; the flush-cycle beat is dropped.
        cycle("F0", 1'b1, 32'h200, 32'hF000_0000, 1'b0, 1'b0, 1'b1);
        cycle("F1", 1'b1, 32'h204, 32'hF000_0001, 1'b1, 1'b0, 1'b1);
        cycle("flush", 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        chk("flush_pc", 64'(pc_o), 64'h40);
        chk("flush_ready", 64'(ready_o), 64'h1);
        chk("flush_nop", 64'(instr_o), 64'(NOP));
        for (int i = 0; i < 3; i++)
            cycle("post_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Counter saturation over a long stall.
        cycle("S0", 1'b1, 32'h300, 32'h5000_0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            cycle("sat", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt", 64'(stall_cnt_o), 64'(CNT_SAT));
        cycle("sat_rel", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-stall with the skid full.
        cycle("R0", 1'b1, 32'h400, 32'h7000_0000, 1'b0, 1'b0, 1'b1);
        cycle("R1", 1'b1, 32'h404, 32'h7000_0001, 1'b1, 1'b0, 1'b1);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk_all("async_rst");
        @(posedge clk); #1;
        rst_i = 1'b0;
        cycle("post_rst", 1'b1, 32'h500, 32'h9000_0000, 1'b0, 1'b0, 1'b1);
        chk("post_rst_pc", 64'(pc_o), 64'h500);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(99) < 70),
                  $urandom, $urandom,
                  ($urandom_range(99) < 30),
                  ($urandom_range(99) < 5),
                  ($urandom_range(99) < 75));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; next generation of the fetch/decode boundary register.
- Carries a PC/instruction pair between any two pipeline stages.
- Adds a valid/ready handshake, a one-entry skid buffer, a configurable NOP pattern and a saturating stall-cycle counter on top of the existing stall/flush control.
- Used at IF/ID first; reusable at ID/EX once payload widths are set.

Parameters:
- PC_W, 32, width of pc_i/pc_o
- INSTR_W, 32, width of instr_i/instr_o
- NOP_INSTR, 0 (INSTR_W bits), pattern driven on instr_o when the stage holds a bubble
- CNT_W, 16, width of the stall counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  upstream beat present
- pc_i  in  PC_W  upstream PC
- instr_i  in  INSTR_W  upstream instruction
- ready_o  out  1  stage can accept a beat this cycle
- stall_i  in  1  hazard-unit stall; blocks downstream advance
- flush_i  in  1  hazard-unit flush; highest priority
- ready_i  in  1  downstream can accept
- valid_o  out  1  main entry holds a valid beat
- pc_o  out  PC_W  main entry PC
- instr_o  out  INSTR_W  main entry instruction (NOP_INSTR when bubble)
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Storage: main entry (valid_o/pc_o/instr_o) plus skid entry (skid_v/skid_pc/skid_instr). All are registered on clk_i.
- Reset (async, immediate): valid_o=0, pc_o=0, instr_o=NOP_INSTR, skid_v=0, stall_cnt_o=0, ready_o=1.
- ready_o = ~skid_v. It is a pure function of state with no combinational path from inputs.
- accept = valid_i & ready_o.
- adv = ready_i & ~stall_i.
- Latency: 1 cycle from accepted beat to valid_o when the main entry is empty or draining. Max occupancy 2.
- Priority order: reset > flush > normal operation.
- Flush (flush_i=1):
  - valid_o<=0, instr_o<=NOP_INSTR, pc_o<=pc_i, skid_v<=0.
  - The incoming beat in the flush cycle is discarded.
  - flush overrides stall_i in the same cycle.
  - ready_o returns to 1 the next cycle.
- Normal operation, by case:
  - Main empty: if accept, main<=input and valid_o<=1. Otherwise hold the bubble (instr_o stays NOP_INSTR).
  - Main full, adv=1, skid full: main<=skid, skid_v<=0. No accept is possible because ready_o=0.
  - Main full, adv=1, skid empty, accept: main<=input.
  - Main full, adv=1, skid empty, no accept: valid_o<=0, instr_o<=NOP_INSTR, pc_o holds.
  - Main full, adv=0, accept: skid<=input, skid_v<=1. Main holds.
  - Main full, adv=0, no accept: everything holds.
- Skid is never written while full; a beat is never lost or duplicated.
- Beat order is strictly FIFO.
- Stall counter: increments when valid_o & ~adv & ~flush_i. Saturates at 2^CNT_W-1 (no wrap). Cleared only by reset.
- Inputs during rst_i=1 are ignored. Deasserting reset mid-stream restarts from empty.

Test Plan:
- Stream A0..A3 (pc 0x0,0x4,0x8,0xC), ready_i=1, stall_i=0 -> each appears on valid_o/pc_o/instr_o exactly 1 cycle after valid_i; ready_o stays 1.
- Hold stall_i=1 for 3 cycles while upstream presents B0 (main) then B1 -> B1 lands in skid; ready_o=0 from the next cycle; stall_cnt_o goes 0→3. On release: B0, then B1, in order; ready_o returns to 1 after skid drains.
- flush_i=1 together with stall_i=1, skid full, valid_i=1, pc_i=0x40 -> next cycle valid_o=0, instr_o=NOP_INSTR, pc_o=0x40, ready_o=1; the discarded beat never appears.
- NOP_INSTR=0x00000013, drain to empty -> instr_o=0x00000013 with valid_o=0; reset also yields 0x00000013.
- CNT_W=3, stall with valid main for 10 cycles -> stall_cnt_o saturates at 7 and holds.
- Assert rst_i asynchronously mid-stall with skid full -> outputs go to reset values before the next clk_i edge; the first beat after reset is accepted normally.
